// File: rtl/firc_sched_if.sv
// Control bundle between the FIR scheduler and the datapath/FIFO it sequences.
// The master is the scheduler. The slave is the datapath and sample-source side.
interface firc_sched_if;
  logic       SampAvail;
  logic       PushCoef;
  logic       SampRd;
  logic [1:0] Phase;
  logic       PhaseVld;
  logic       ZeroB;
  logic       CoefWrEn;
  logic       CoefRdy;
  logic       AccClr;
  logic       AccEn;
  logic       PushOut;
  logic       Busy;

  modport master (
    input  SampAvail, PushCoef,
    output SampRd, Phase, PhaseVld, ZeroB, CoefWrEn, CoefRdy,
           AccClr, AccEn, PushOut, Busy
  );

  modport slave (
    output SampAvail, PushCoef,
    input  SampRd, Phase, PhaseVld, ZeroB, CoefWrEn, CoefRdy,
           AccClr, AccEn, PushOut, Busy
  );
endinterface

// File: rtl/firc_sched.sv
// Sequencer for the 29-tap symmetric complex FIR. It runs three tap-group phases per sample,
// tracks phase tags to the accumulator, and grants coefficient writes when the pipeline is drained.
module firc_sched #(
  parameter int PIPE_LAT = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  firc_sched_if.master bus
);

  typedef enum logic [1:0] {IDLE, P0, P1, P2} state_t;

  state_t                     state_reg, state_next;
  logic [PIPE_LAT-1:0]        tag_vld_reg, tag_vld_next;
  logic [PIPE_LAT-1:0][1:0]   tag_phase_reg, tag_phase_next;
  logic                       push_out_reg;

  logic       start;
  logic       samp_rd;
  logic [1:0] phase;
  logic       phase_vld;
  logic       zero_b;
  logic       coef_rdy;
  logic       tag_out_vld;
  logic [1:0] tag_out_phase;

  // Reset also masks the pop, so a held SampAvail cannot drain the FIFO during reset.
  assign start = bus.SampAvail & ~bus.PushCoef & ~Reset;

  always_comb begin
    state_next = state_reg;
    samp_rd    = 1'b0;
    phase      = 2'd3;
    phase_vld  = 1'b0;
    zero_b     = 1'b0;
    case (state_reg)
      IDLE: begin
        samp_rd = start;
        if (start) state_next = P0;
      end
      P0: begin
        phase      = 2'd0;
        phase_vld  = 1'b1;
        state_next = P1;
      end
      P1: begin
        phase      = 2'd1;
        phase_vld  = 1'b1;
        state_next = P2;
      end
      P2: begin
        phase      = 2'd2;
        phase_vld  = 1'b1;
        zero_b     = 1'b1;
        samp_rd    = start;
        state_next = start ? P0 : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Tag shift mirrors the adder + multiplier stages so control lines up with each product.
  for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_tag
    if (gi == 0) begin : g_head
      assign tag_vld_next[gi]   = phase_vld;
      assign tag_phase_next[gi] = phase;
    end else begin : g_body
      assign tag_vld_next[gi]   = tag_vld_reg[gi-1];
      assign tag_phase_next[gi] = tag_phase_reg[gi-1];
    end
  end

  assign tag_out_vld   = tag_vld_reg[PIPE_LAT-1];
  assign tag_out_phase = tag_phase_reg[PIPE_LAT-1];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg     <= IDLE;
      tag_vld_reg   <= '0;
      tag_phase_reg <= '0;
      push_out_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tag_vld_reg   <= tag_vld_next;
      tag_phase_reg <= tag_phase_next;
      push_out_reg  <= tag_out_vld & (tag_out_phase == 2'd2);
    end
  end

  assign coef_rdy = (state_reg == IDLE) & ~(|tag_vld_reg);

  assign bus.SampRd   = samp_rd;
  assign bus.Phase    = phase;
  assign bus.PhaseVld = phase_vld;
  assign bus.ZeroB    = zero_b;
  assign bus.CoefRdy  = coef_rdy;
  assign bus.CoefWrEn = bus.PushCoef & coef_rdy & ~Reset;
  assign bus.AccEn    = tag_out_vld;
  assign bus.AccClr   = tag_out_vld & (tag_out_phase == 2'd0);
  assign bus.PushOut  = push_out_reg;
  assign bus.Busy     = (state_reg != IDLE) | (|tag_vld_reg) | push_out_reg;

endmodule

// File: tb/tb_firc_sched.sv
// Directed bench for firc_sched. It covers reset, the single-sample timeline, streaming, the coefficient
// handshake, an abort by reset, and the case where a coefficient request collides with a sample start.
module tb_firc_sched;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  firc_sched_if bus ();

  firc_sched #(.PIPE_LAT(3)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // {SampRd, Phase[1:0], PhaseVld, ZeroB, CoefWrEn, CoefRdy, AccClr, AccEn, PushOut, Busy}
  localparam logic [10:0] V_IDLE = 11'b0_11_0_0_0_1_0_0_0_0;

  function automatic logic [10:0] ov();
    return {bus.SampRd, bus.Phase, bus.PhaseVld, bus.ZeroB, bus.CoefWrEn, bus.CoefRdy,
            bus.AccClr, bus.AccEn, bus.PushOut, bus.Busy};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1ns later.
  task automatic cyc();
    @(negedge Clk);
  endtask

  task automatic drain(input int n, output int po, output int rd);
    po = 0;
    rd = 0;
    repeat (n) begin
      cyc();
      #1;
      if (bus.PushOut) po++;
      if (bus.SampRd) rd++;
    end
  endtask

  logic [10:0] exp2 [9] = '{
    11'b1_11_0_0_0_1_0_0_0_0,   // t0: IDLE, pop
    11'b0_00_1_0_0_0_0_0_0_1,   // P0
    11'b0_01_1_0_0_0_0_0_0_1,   // P1
    11'b0_10_1_1_0_0_0_0_0_1,   // P2, centre tap
    11'b0_11_0_0_0_0_1_1_0_1,   // group 0 product: clear
    11'b0_11_0_0_0_0_0_1_0_1,   // group 1 product
    11'b0_11_0_0_0_0_0_1_0_1,   // group 2 product
    11'b0_11_0_0_0_1_0_0_1_1,   // PushOut
    V_IDLE
  };

  int rd_cyc[$];
  int po_cyc[$];
  int underflow;
  int bad;
  int po;
  int rd;
  int wr;

  initial begin
    Reset = 1'b1;
    bus.SampAvail = 1'b0;
    bus.PushCoef  = 1'b0;

    // Test 1: reset, then the block stays idle.
    cyc();
    cyc();
    #1 chk("reset_vec", ov(), V_IDLE);
    cyc();
    Reset = 1'b0;
    #1 chk("reset_release", ov(), V_IDLE);
    bad = 0;
    repeat (20) begin
      cyc();
      #1;
      if (ov() !== V_IDLE) bad++;
    end
    chk("idle_20", bad, 0);

    // Test 2: single-sample timeline.
    for (int k = 0; k < 9; k++) begin
      cyc();
      bus.SampAvail = (k == 0);
      #1 chk($sformatf("single_t%0d", k), ov(), exp2[k]);
    end

    // Test 3: a 10-sample stream.
    underflow = 0;
    for (int c = 0; c < 70; c++) begin
      cyc();
      bus.SampAvail = (rd_cyc.size() < 10);
      #1;
      if (bus.SampRd) begin
        if (!bus.SampAvail) underflow++;
        rd_cyc.push_back(c);
      end
      if (bus.PushOut) po_cyc.push_back(c);
    end
    chk("stream_rd_count", rd_cyc.size(), 10);
    chk("stream_po_count", po_cyc.size(), 10);
    chk("stream_underflow", underflow, 0);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (rd_cyc[k] != 3 * k) bad++;
      if (po_cyc[k] != 3 * k + 7) bad++;
    end
    chk("stream_spacing", bad, 0);
    chk("stream_end_idle", ov(), V_IDLE);

    // Test 4: coefficient request during P1 of a busy stream.
    for (int c = 0; c < 5; c++) begin
      cyc();
      bus.SampAvail = 1'b1;
      #1;
      if (c == 0) chk("coef_rd0", bus.SampRd, 1'b1);
      if (c == 3) chk("coef_rd3", bus.SampRd, 1'b1);
    end
    cyc();
    bus.PushCoef = 1'b1;
    #1 chk("coef_in_p1", bus.Phase, 2'd1);
    cyc();
    #1 chk("coef_p2_phase", bus.Phase, 2'd2);
    chk("coef_p2_no_rd", bus.SampRd, 1'b0);
    cyc();
    #1 chk("coef_idle_phase", bus.Phase, 2'd3);
    wr = 0;
    if (bus.CoefWrEn) wr++;
    repeat (2) begin
      cyc();
      #1;
      if (bus.CoefWrEn) wr++;
    end
    chk("coef_drain_no_wr", wr, 0);
    wr = 0;
    rd = 0;
    for (int c = 0; c < 29; c++) begin
      cyc();
      #1;
      if (c == 0) begin
        chk("coef_first_grant", bus.CoefWrEn, 1'b1);
        chk("coef_last_push", bus.PushOut, 1'b1);
      end
      if (bus.CoefWrEn) wr++;
      if (bus.SampRd) rd++;
    end
    chk("coef_writes", wr, 29);
    chk("coef_hold_no_rd", rd, 0);
    cyc();
    bus.PushCoef = 1'b0;
    #1 chk("coef_resume_rd", bus.SampRd, 1'b1);
    chk("coef_resume_no_wr", bus.CoefWrEn, 1'b0);
    cyc();
    bus.SampAvail = 1'b0;
    #1;
    drain(12, po, rd);
    chk("coef_resume_push", po, 1);

    // Test 5: reset in P1 with two samples in flight.
    for (int c = 0; c < 5; c++) begin
      cyc();
      bus.SampAvail = 1'b1;
      #1;
    end
    cyc();
    Reset = 1'b1;
    #1 chk("rst_in_p1", bus.Phase, 2'd1);
    chk("rst_inflight_acc", bus.AccEn, 1'b1);
    chk("rst_no_rd", bus.SampRd, 1'b0);
    cyc();
    Reset = 1'b0;
    bus.SampAvail = 1'b0;
    #1 chk("rst_abort_vec", ov(), V_IDLE);
    bad = 0;
    po = 0;
    repeat (10) begin
      cyc();
      #1;
      if (bus.PushOut) po++;
      if (ov() !== V_IDLE) bad++;
    end
    chk("rst_no_push", po, 0);
    chk("rst_stay_idle", bad, 0);
    cyc();
    bus.SampAvail = 1'b1;
    #1 chk("rst_reissue", bus.SampRd, 1'b1);
    cyc();
    bus.SampAvail = 1'b0;
    #1;
    drain(12, po, rd);
    chk("rst_reissue_push", po, 1);

    // Test 6: a coefficient request collides with a sample start.
    cyc();
    bus.SampAvail = 1'b1;
    bus.PushCoef  = 1'b1;
    #1 chk("collide_wr", bus.CoefWrEn, 1'b1);
    chk("collide_no_rd", bus.SampRd, 1'b0);
    cyc();
    bus.PushCoef = 1'b0;
    #1 chk("collide_then_rd", bus.SampRd, 1'b1);
    cyc();
    bus.SampAvail = 1'b0;
    #1;
    drain(12, po, rd);
    chk("collide_push", po, 1);
    chk("final_idle", ov(), V_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
